// File: rtl/i2s_tx_if.sv
// I2S master transmitter: divides the system clock into SCK/WS, buffers tagged
// stereo words from AXI4-Stream in a small FIFO and serialises them Philips-style.
module i2s_tx_if #(
  parameter int unsigned clkdiv_val = 20,
  parameter int unsigned fifo_depth = 4
) (
  input  logic        s_axis_aclk,
  input  logic        s_axis_aresetn,
  input  logic [31:0] s_axis_tdata,
  input  logic        s_axis_tuser,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic        SCK,
  output logic        WS,
  output logic        SD,
  output logic        underrun,
  output logic        misalign
);

  localparam int unsigned CW = $clog2(clkdiv_val + 1);
  localparam int unsigned AW = $clog2(fifo_depth);
  localparam logic [CW-1:0] DIV_MAX  = CW'(clkdiv_val);
  localparam logic [CW-1:0] DIV_HALF = CW'(clkdiv_val / 2);
  localparam logic [AW:0]   FULL     = (AW+1)'(fifo_depth);

  typedef struct packed {
    logic        tag;
    logic [31:0] data;
  } beat_t;

  logic [CW-1:0] div_q, div_d;
  logic [4:0]    bit_q, bit_d;
  logic          sck_q, sck_d;
  logic          ws_q, ws_d;
  logic          sd_q, sd_d;
  logic [31:0]   shift_q, shift_d;
  logic          ur_q, ur_d;
  logic          ma_q, ma_d;
  logic          rdy_q, rdy_d;
  logic          armed_q, armed_d;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  beat_t         mem_q [fifo_depth];

  logic          tick, load, empty, push, pop;
  beat_t         head;
  logic [31:0]   word;

  always_comb begin
    tick    = (div_q == DIV_MAX);
    div_d   = tick ? '0 : div_q + 1'b1;
    sck_d   = sck_q;
    if (tick)                  sck_d = 1'b0;
    else if (div_q == DIV_HALF) sck_d = 1'b1;
    bit_d   = tick ? bit_q + 5'd1 : bit_q;
    ws_d    = (tick && bit_q == 5'd31) ? ~ws_q : ws_q;
    // The very first bit_cnt==0 tick precedes any WS edge, so no slot exists yet.
    armed_d = armed_q | (tick && bit_q == 5'd31);
    load    = tick && (bit_q == 5'd0) && armed_q;

    head    = mem_q[rd_q];
    empty   = (cnt_q == '0);
    pop     = load && !empty && (head.tag == ws_q);
    ur_d    = load && empty;
    ma_d    = load && !empty && (head.tag != ws_q);
    word    = pop ? head.data : '0;

    sd_d    = sd_q;
    shift_d = shift_q;
    if (load) begin
      sd_d    = word[31];
      shift_d = {word[30:0], 1'b0};
    end else if (tick) begin
      sd_d    = shift_q[31];
      shift_d = {shift_q[30:0], 1'b0};
    end

    // Load decision uses cnt_q, so a beat pushed on the load cycle waits.
    push  = s_axis_tvalid && rdy_q;
    wr_d  = push ? wr_q + 1'b1 : wr_q;
    rd_d  = pop  ? rd_q + 1'b1 : rd_q;
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    rdy_d = (cnt_d != FULL);
  end

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      div_q   <= '0;
      bit_q   <= '0;
      sck_q   <= 1'b0;
      ws_q    <= 1'b0;
      sd_q    <= 1'b0;
      shift_q <= '0;
      ur_q    <= 1'b0;
      ma_q    <= 1'b0;
      rdy_q   <= 1'b0;
      armed_q <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
    end else begin
      div_q   <= div_d;
      bit_q   <= bit_d;
      sck_q   <= sck_d;
      ws_q    <= ws_d;
      sd_q    <= sd_d;
      shift_q <= shift_d;
      ur_q    <= ur_d;
      ma_q    <= ma_d;
      rdy_q   <= rdy_d;
      armed_q <= armed_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge s_axis_aclk) begin
    if (push) mem_q[wr_q] <= '{tag: s_axis_tuser, data: s_axis_tdata};
  end

  assign s_axis_tready = rdy_q;
  assign SCK           = sck_q;
  assign WS            = ws_q;
  assign SD            = sd_q;
  assign underrun      = ur_q;
  assign misalign      = ma_q;

endmodule

// File: tb/tb_i2s_tx_if.sv
// Directed bench for i2s_tx_if: waveform timing, Philips receiver, FIFO flow control, reset.
module tb_i2s_tx_if;
  localparam int PER = 21;
  localparam logic [31:0] W1 = 32'h1234_5678;
  localparam logic [31:0] R1 = 32'h8000_0001;
  localparam logic [31:0] L1 = 32'hA5A5_0F0F;
  localparam logic [31:0] R2 = 32'hCAFE_F00D;
  localparam logic [31:0] R3 = 32'hFFFF_0000;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] tdata = '0;
  logic        tuser = 1'b0;
  logic        tvalid = 1'b0;
  logic        tready, sck, ws, sd, ur, ma;
  int          total = 0;
  int          bad = 0;
  int          n_edge = 0;

  always #5 clk = ~clk;

  i2s_tx_if #(.clkdiv_val(20), .fifo_depth(4)) dut (
    .s_axis_aclk(clk), .s_axis_aresetn(rstn), .s_axis_tdata(tdata),
    .s_axis_tuser(tuser), .s_axis_tvalid(tvalid), .s_axis_tready(tready),
    .SCK(sck), .WS(ws), .SD(sd), .underrun(ur), .misalign(ma));

  always @(posedge clk or negedge rstn)
    if (!rstn) n_edge <= 0;
    else       n_edge <= n_edge + 1;

  // Receiver: samples on SCK rise; the bit taken at a WS change is the previous word's LSB.
  logic [31:0] rx_sh, rx_nw;
  logic        sck_prev, ws_prev, rx_started;
  logic [31:0] rx_words[$];
  logic        rx_chs[$];
  logic        ur_f[16], ma_f[16];
  int          stray, mk, mj;

  always @(negedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_sh = '0; sck_prev = 1'b0; ws_prev = 1'b0; rx_started = 1'b0; stray = 0;
      rx_words.delete(); rx_chs.delete();
      for (int j = 0; j < 16; j++) begin ur_f[j] = 1'b0; ma_f[j] = 1'b0; end
    end else begin
      if (sck === 1'b1 && sck_prev === 1'b0) begin
        rx_nw = {rx_sh[30:0], sd};
        if (ws !== ws_prev) begin
          if (rx_started) begin rx_words.push_back(rx_nw); rx_chs.push_back(ws_prev); end
          rx_started = 1'b1;
        end
        rx_sh = rx_nw;
        ws_prev = ws;
      end
      sck_prev = sck;
      if (ur === 1'b1 || ma === 1'b1) begin
        mk = n_edge / PER;
        if (n_edge % PER == 0 && mk >= 33 && (mk - 33) % 32 == 0 && (mk - 33) / 32 < 16) begin
          mj = (mk - 33) / 32;
          if (ur === 1'b1) ur_f[mj] = 1'b1;
          if (ma === 1'b1) ma_f[mj] = 1'b1;
        end else stray++;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic goto(input int e);
    while (n_edge < e) step();
  endtask

  task automatic push_word(input logic [31:0] d, input logic u, output int acc, output logic rdy_after);
    bit ok;
    int guard;
    tvalid = 1'b1; tdata = d; tuser = u; acc = -1; guard = 0;
    do begin
      ok = (tready === 1'b1);
      step();
      guard++;
    end while (!ok && guard < 4000);
    tvalid = 1'b0;
    if (ok) acc = n_edge;
    rdy_after = tready;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " sck"}, sck, 0);
    chk({tag, " ws"}, ws, 0);
    chk({tag, " sd"}, sd, 0);
    chk({tag, " underrun"}, ur, 0);
    chk({tag, " misalign"}, ma, 0);
    chk({tag, " tready"}, tready, 0);
  endtask

  // Idle timing from release: expected levels derived from edge index alone.
  task automatic check_timing(input string tag);
    int e_sck, e_ws, e_sd, e_ur, e_ma, e_rdy, n_ur, n, k;
    logic x_sck, x_ws, x_ur;
    e_sck = 0; e_ws = 0; e_sd = 0; e_ur = 0; e_ma = 0; e_rdy = 0; n_ur = 0;
    for (int i = 0; i < 2100; i++) begin
      step();
      n = n_edge;
      k = n / PER;
      x_sck = (n % PER >= 11);
      x_ws  = ((k / 32) % 2) == 1;
      x_ur  = (n % PER == 0) && (k >= 33) && (k % 32 == 1);
      if (sck !== x_sck) e_sck++;
      if (ws !== x_ws) e_ws++;
      if (sd !== 1'b0) e_sd++;
      if (ur !== x_ur) e_ur++;
      if (ma !== 1'b0) e_ma++;
      if (tready !== 1'b1) e_rdy++;
      if (ur === 1'b1) n_ur++;
    end
    chk({tag, " sck_bad_edges"}, e_sck, 0);
    chk({tag, " ws_bad_edges"}, e_ws, 0);
    chk({tag, " sd_bad_edges"}, e_sd, 0);
    chk({tag, " underrun_bad_edges"}, e_ur, 0);
    chk({tag, " misalign_bad_edges"}, e_ma, 0);
    chk({tag, " tready_bad_edges"}, e_rdy, 0);
    chk({tag, " underrun_pulses"}, n_ur, 3);
  endtask

  typedef struct {
    logic        do_push;
    logic [31:0] data;
    logic        user;
    int          exp_acc;
    logic        exp_rdy;
    logic        exp_ch;
    logic [31:0] exp_word;
    logic        exp_ur;
    logic        exp_ma;
  } vec_t;

  vec_t tbl[12];

  initial begin
    int acc;
    logic rdy;

    // Entry i: the i-th beat offered (if any) and the outcome of slot i.
    tbl[0]  = '{1'b1, W1, 1'b0,    2, 1'b1, 1'b1, 32'h0, 1'b0, 1'b1};
    tbl[1]  = '{1'b1, R1, 1'b1,    3, 1'b1, 1'b0, W1,    1'b0, 1'b0};
    tbl[2]  = '{1'b1, L1, 1'b0,    4, 1'b1, 1'b1, R1,    1'b0, 1'b0};
    tbl[3]  = '{1'b1, R1, 1'b1,    5, 1'b0, 1'b0, L1,    1'b0, 1'b0};
    tbl[4]  = '{1'b1, L1, 1'b0, 1366, 1'b0, 1'b1, R1,    1'b0, 1'b0};
    tbl[5]  = '{1'b1, R1, 1'b1, 2038, 1'b0, 1'b0, L1,    1'b0, 1'b0};
    tbl[6]  = '{1'b1, L1, 1'b0, 2710, 1'b0, 1'b1, R1,    1'b0, 1'b0};
    tbl[7]  = '{1'b0, 0,  1'b0,    0, 1'b0, 1'b0, L1,    1'b0, 1'b0};
    tbl[8]  = '{1'b0, 0,  1'b0,    0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 0,  1'b0,    0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 0,  1'b0,    0, 1'b0, 1'b1, R2,    1'b0, 1'b0};
    tbl[11] = '{1'b0, 0,  1'b0,    0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0};

    // Reset state, then idle timing.
    repeat (3) step();
    chk_zero("reset");
    rstn = 1'b1;
    check_timing("idle");

    // Fresh start for the data phase.
    rstn = 1'b0;
    step(); step();
    rstn = 1'b1;
    goto(1);
    for (int i = 0; i < 12; i++) begin
      if (tbl[i].do_push) begin
        push_word(tbl[i].data, tbl[i].user, acc, rdy);
        chk($sformatf("accept_edge[%0d]", i), acc, tbl[i].exp_acc);
        chk($sformatf("tready_after[%0d]", i), rdy, tbl[i].exp_rdy);
      end
    end

    // Push lands on the load edge of an empty slot.
    goto(6068);
    tvalid = 1'b1; tdata = R2; tuser = 1'b1;
    chk("tready_before_load", tready, 1);
    step();
    tvalid = 1'b0;
    chk("load_edge_underrun", ur, 1);
    chk("load_edge_sd", sd, 0);

    goto(8740);
    push_word(R3, 1'b1, acc, rdy);
    chk("accept_r3", acc, 8741);
    push_word(L1, 1'b0, acc, rdy);
    chk("accept_l1", acc, 8742);

    goto(8760);
    chk("rx_count_ok", (rx_words.size() >= 12), 1);
    for (int i = 0; i < 12; i++) begin
      if (i < rx_words.size()) begin
        chk($sformatf("slot[%0d] word", i), rx_words[i], tbl[i].exp_word);
        chk($sformatf("slot[%0d] ch", i), rx_chs[i], tbl[i].exp_ch);
      end
      chk($sformatf("slot[%0d] underrun", i), ur_f[i], tbl[i].exp_ur);
      chk($sformatf("slot[%0d] misalign", i), ma_f[i], tbl[i].exp_ma);
    end
    chk("stray_pulses", stray, 0);

    // Mid-word reset at bit_cnt 15 of slot 12 (R3 bit 17 on SD).
    goto(9066);
    chk("pre_rst sck", sck, 1);
    chk("pre_rst ws", ws, 1);
    chk("pre_rst sd", sd, 1);
    chk("pre_rst tready", tready, 1);
    #2 rstn = 1'b0;
    #1 chk_zero("async_rst");
    repeat (3) step();
    chk_zero("held_rst");
    rstn = 1'b1;
    check_timing("after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not reach summary (total=%0d bad=%0d)", total, bad);
    $fatal(1);
  end

endmodule

// File: doc/i2s_tx_if.md
# i2s_tx_if

I2S master transmitter: generates SCK and WS from the system clock and serialises 32-bit stereo words from an AXI4-Stream slave onto a single SD line. Drives the sonar transmit DAC/amplifier; its clocking is cycle-compatible with `i2s_if` (same divider and word-select phase), so both can share one set of timing assumptions. A small internal FIFO absorbs DMA jitter; starvation and channel slips are flagged, never stalled.

## Interface
- `clkdiv_val`, 20, SCK period = clkdiv_val+1 clock cycles; must be ≥ 3.
- `fifo_depth`, 4, input FIFO entries; power of 2, ≥ 2.
- `s_axis_aclk`  in  1  sole clock.
- `s_axis_aresetn`  in  1  reset; asynchronous, active-low.
- `s_axis_tdata`  in  32  sample word, MSB first on the wire.
- `s_axis_tuser`  in  1  channel tag: 0 = left (WS=0), 1 = right (WS=1).
- `s_axis_tvalid`  in  1  beat valid.
- `s_axis_tready`  out  1  = FIFO not full.
- `SCK`  out  1  I2S bit clock.
- `WS`  out  1  I2S word select.
- `SD`  out  1  I2S serial data.
- `underrun`  out  1  one-cycle pulse: slot transmitted as zero, FIFO empty.
- `misalign`  out  1  one-cycle pulse: slot transmitted as zero, head tag ≠ slot channel.

## Operation
- `clkdiv_cnt` counts 0..clkdiv_val, wraps; `tick` = (clkdiv_cnt == clkdiv_val).
- SCK ← 0 on tick; SCK ← 1 when clkdiv_cnt == clkdiv_val/2 (integer division).
- `bit_cnt` (5 bits) increments on tick, wraps 31→0.
- WS toggles on tick when bit_cnt == 31; each WS level lasts 32 SCK periods, frame = 64 SCK.
- Philips one-bit delay: on tick with bit_cnt == 0 (slot channel = current WS) the load event occurs:
  - FIFO empty → load 0, pulse `underrun`, no pop.
  - head tag ≠ WS → load 0, pulse `misalign`, no pop (head waits for its own channel slot; self-resynchronises).
  - otherwise pop head, load its tdata.
  - SD ← loaded[31]; shift register ← loaded[30:0] with zero fill.
- Every other tick: SD ← shift[31], shift left by 1. LSB is therefore driven during bit_cnt == 0 of the following slot (after the WS edge).
- SD, WS change only on tick (SCK falling edge); a receiver samples on SCK rising edge.
- FIFO: push when tvalid && tready; pop only at load event. Push and pop in the same cycle both take effect. Pushed word is not visible to a load in the same cycle (no bypass): empty FIFO + push on load cycle → underrun, word kept for a later slot.
- tdata/tuser held by the FIFO; no other data path from input to SD.

## Timing
- Reset (async assert): SCK=0, WS=0, SD=0, underrun=0, misalign=0, s_axis_tready=0, FIFO emptied, counters=0, shift register=0. Reset assertion mid-frame aborts immediately; no partial word resumes.
- After deassert: tready=1 from the first clock edge; first tick at cycle clkdiv_val+1; first WS toggle at the 32nd tick (WS→1); first load at the 33rd tick, i.e. first transmitted slot is right-channel.
- All outputs registered; underrun/misalign high exactly one cycle, coincident with SD taking the slot MSB.
- Beat accepted at edge t is poppable from edge t+1.
- Full: tready=0 from the cycle after the push that fills; pop on a full FIFO raises tready the next cycle.
- Latency from acceptance into an idle, aligned FIFO to MSB on SD: up to 64 SCK periods (waits for its channel's load tick).

## Test plan
- Reset release, no input: SCK period 21 cycles (clkdiv_val=20), high 10 cycles; WS toggles every 32 SCK; SD stays 0; underrun pulses once per slot from the 33rd tick onward.
- Push L=0xA5A5_0F0F (tuser 0), R=0x8000_0001 (tuser 1) repeatedly: bench receiver sampling on SCK rise with one-bit delay recovers identical words per channel; no underrun/misalign after the first frame.
- Push a left-tagged word while the first slot is right: one `misalign` pulse, zero right slot, word emitted on next left slot, alignment held thereafter.
- Hold tvalid high with no consumption: tready drops after exactly fifo_depth=4 accepts; rises one cycle after the next pop.
- Empty FIFO with push on the load cycle: `underrun` pulses, word appears in the same-channel slot one frame later.
- Assert reset mid-word (bit_cnt=15): all outputs 0 immediately, FIFO empty; after release, timing matches the first scenario exactly.
